// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage. It serves one byte, half, word or double
// load/store at a time against a single-port 32-bit RAM. Double accesses take two
// RAM beats. The pipeline is held with stall_o until the response cycle.
module dmem_responder #(
  parameter int unsigned N     = 64,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         req_i,
  input  logic         we_i,
  input  logic [1:0]   size_i,
  input  logic         sext_i,
  input  logic [N-1:0] addr_i,
  input  logic [N-1:0] wdata_i,
  output logic [N-1:0] rdata_o,
  output logic         stall_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [1:0] {StIdle, StAccLo, StAccHi, StResp} state_e;

  state_e          state_q, state_d;
  logic [AW+1:0]   addr_q;
  logic [N-1:0]    wdata_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            sext_q;
  logic            mis_q;
  logic [N-1:0]    rbuf_q, rbuf_d;
  logic [N-1:0]    rdata_q, rdata_d;
  logic [31:0]     mem_q [DEPTH];

  logic            mis_in;
  logic [AW-1:0]   lo_idx, mem_idx;
  logic [31:0]     mem_rword, mem_wword, mem_merged;
  logic [3:0]      mem_be;
  logic            mem_we;
  logic            resp_load;
  logic [7:0]      lane8;
  logic [15:0]     lane16;
  logic [N-1:0]    fmt;

  // Address bits above the RAM index wrap and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^addr_i[N-1:AW+2];

  // Alignment check on the live request inputs, evaluated in the sampling cycle.
  always_comb begin
    unique case (size_i)
      2'b00:   mis_in = 1'b0;
      2'b01:   mis_in = addr_i[0];
      2'b10:   mis_in = |addr_i[1:0];
      default: mis_in = |addr_i[2:0];
    endcase
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    err_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall_o = req_i;
        if (req_i) state_d = mis_in ? StResp : StAccLo;
      end
      StAccLo: begin
        stall_o = 1'b1;
        state_d = (size_q == 2'b11) ? StAccHi : StResp;
      end
      StAccHi: begin
        stall_o = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        done_o  = 1'b1;
        err_o   = mis_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // RAM port: word select, byte-enable generation and little-endian merge.
  always_comb begin
    lo_idx    = addr_q[AW+1:2];
    mem_idx   = (state_q == StAccHi) ? lo_idx + AW'(1) : lo_idx;
    mem_rword = mem_q[mem_idx];
    mem_we    = we_q && ((state_q == StAccLo) || (state_q == StAccHi));
    mem_be    = 4'b1111;
    mem_wword = wdata_q[31:0];
    if (state_q == StAccHi) begin
      mem_wword = wdata_q[63:32];
    end else begin
      unique case (size_q)
        2'b00: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wword = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          mem_wword = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wword = wdata_q[31:0];
        end
      endcase
    end
    for (int b = 0; b < 4; b++) begin
      mem_merged[8*b +: 8] = mem_be[b] ? mem_wword[8*b +: 8] : mem_rword[8*b +: 8];
    end
  end

  // Read buffer and load formatting; rdata is formatted from the beat being latched
  // so it is already valid in the first RESP cycle.
  always_comb begin
    rbuf_d = rbuf_q;
    if (state_q == StAccLo) rbuf_d[31:0]  = mem_rword;
    if (state_q == StAccHi) rbuf_d[63:32] = mem_rword;
    resp_load = !we_q && (((state_q == StAccLo) && (size_q != 2'b11)) ||
                          (state_q == StAccHi));
    lane8  = rbuf_d[{addr_q[1:0], 3'b000} +: 8];
    lane16 = addr_q[1] ? rbuf_d[31:16] : rbuf_d[15:0];
    unique case (size_q)
      2'b00:   fmt = {{(N-8){sext_q & lane8[7]}}, lane8};
      2'b01:   fmt = {{(N-16){sext_q & lane16[15]}}, lane16};
      2'b10:   fmt = {{(N-32){sext_q & rbuf_d[31]}}, rbuf_d[31:0]};
      default: fmt = rbuf_d;
    endcase
    rdata_d = resp_load ? fmt : rdata_q;
  end

  // State, request capture and result registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      mis_q   <= 1'b0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      if (state_q == StIdle && req_i) begin
        addr_q  <= addr_i[AW+1:0];
        wdata_q <= wdata_i;
        we_q    <= we_i;
        size_q  <= size_i;
        sext_q  <= sext_i;
        mis_q   <= mis_in;
      end
    end
  end

  // RAM array; not reset. A reset forces IDLE asynchronously, which blocks the write.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_idx] <= mem_merged;
  end

  assign rdata_o = rdata_q;

endmodule
